// File: rtl/bit_serial_sum_collector.sv
// Purpose : drives a bit-serial adder (load strobe, shift enable) and collects its sum bits into a word.
// Latency : DATA_WIDTH+1 cycles from operand accept to the first m_valid cycle (no ce stalls).
// Backpr. : s_ready is low in SHIFT and DONE; m_valid and m_sum hold in DONE until m_ready on a ce edge.
//
// Ports:
//   clk, rst (async, active-low), ce (global clock enable, shared with the adder)
//   s_valid/s_ready/s_a0/s_a1 : operand pair in
//   add_load/add_en/add_a0/add_a1/add_bit : adder control, operands out, serial sum bit in
//   m_valid/m_ready/m_sum : collected sum out
//   busy : high whenever the FSM is not IDLE
module bit_serial_sum_collector #(
  parameter  int DATA_WIDTH = 1025,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a0,
  input  logic [DATA_WIDTH-1:0] s_a1,
  output logic                  add_load,
  output logic                  add_en,
  output logic [DATA_WIDTH-1:0] add_a0,
  output logic [DATA_WIDTH-1:0] add_a1,
  input  logic                  add_bit,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_sum,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic [DATA_WIDTH-1:0]   sum_d;
  logic                    m_valid_q;
  logic                    add_en_q;
  logic                    busy_q;

  // Sum bits arrive LSB first; after DATA_WIDTH shifts the first bit sits in bit 0.
  always_comb begin
    sum_d = {add_bit, sum_q[DATA_WIDTH-1:1]};
    cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      m_valid_q <= 1'b0;
      add_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            state_q  <= SHIFT;
            cnt_q    <= '0;
            add_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SHIFT: begin
          sum_q <= sum_d;
          cnt_q <= cnt_d;
          // Dropping add_en on the capture of the last bit keeps the adder
          // enabled for exactly DATA_WIDTH ce-cycles.
          if (cnt_q == LAST_BIT) begin
            state_q   <= DONE;
            add_en_q  <= 1'b0;
            m_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (m_ready) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          add_en_q  <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Load is combinational so the adder latches operands on the same edge
  // this block leaves IDLE; it cannot overlap add_en, which is high only in SHIFT.
  // rst gating keeps ready/load quiet while reset is held.
  assign s_ready  = (state_q == IDLE) & rst;
  assign add_load = (state_q == IDLE) & s_valid & ce & rst;
  assign add_en   = add_en_q;
  assign add_a0   = s_a0;
  assign add_a1   = s_a1;
  assign m_valid  = m_valid_q;
  assign m_sum    = sum_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bit_serial_sum_collector.sv
module tb_bit_serial_sum_collector;

  localparam int WB = 1025;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- 8-bit instance ----------------
  logic       ce8, sv8, sr8, ld8, en8, bit8, mv8, mr8, busy8;
  logic [7:0] a0_8, a1_8, aa0_8, aa1_8, sum8;

  bit_serial_sum_collector #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .ce(ce8),
    .s_valid(sv8), .s_ready(sr8), .s_a0(a0_8), .s_a1(a1_8),
    .add_load(ld8), .add_en(en8), .add_a0(aa0_8), .add_a1(aa1_8), .add_bit(bit8),
    .m_valid(mv8), .m_ready(mr8), .m_sum(sum8), .busy(busy8)
  );

  // Bit-serial adder stand-in: loads on add_load, shifts on add_en, both gated by ce.
  logic [7:0] ra0_8, ra1_8;
  logic       c8;
  assign bit8 = ra0_8[0] ^ ra1_8[0] ^ c8;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra0_8 <= '0; ra1_8 <= '0; c8 <= 1'b0;
    end else if (ce8) begin
      if (ld8) begin
        ra0_8 <= aa0_8; ra1_8 <= aa1_8; c8 <= 1'b0;
      end else if (en8) begin
        ra0_8 <= ra0_8 >> 1; ra1_8 <= ra1_8 >> 1;
        c8    <= (ra0_8[0] & ra1_8[0]) | (ra0_8[0] & c8) | (ra1_8[0] & c8);
      end
    end
  end

  // ---------------- default-width instance ----------------
  logic          ceb, svb, srb, ldb, enb, bitb, mvb, mrb, busyb;
  logic [WB-1:0] a0_b, a1_b, aa0_b, aa1_b, sumb;

  bit_serial_sum_collector ub (
    .clk(clk), .rst(rst), .ce(ceb),
    .s_valid(svb), .s_ready(srb), .s_a0(a0_b), .s_a1(a1_b),
    .add_load(ldb), .add_en(enb), .add_a0(aa0_b), .add_a1(aa1_b), .add_bit(bitb),
    .m_valid(mvb), .m_ready(mrb), .m_sum(sumb), .busy(busyb)
  );

  logic [WB-1:0] ra0_b, ra1_b;
  logic          cb;
  assign bitb = ra0_b[0] ^ ra1_b[0] ^ cb;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra0_b <= '0; ra1_b <= '0; cb <= 1'b0;
    end else if (ceb) begin
      if (ldb) begin
        ra0_b <= aa0_b; ra1_b <= aa1_b; cb <= 1'b0;
      end else if (enb) begin
        ra0_b <= ra0_b >> 1; ra1_b <= ra1_b >> 1;
        cb    <= (ra0_b[0] & ra1_b[0]) | (ra0_b[0] & cb) | (ra1_b[0] & cb);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (low 128 bits shown)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // One 8-bit transaction; entered and left on a negedge.
  // hold: extra cycles m_ready stays low after m_valid; toggle: ce alternates during SHIFT.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit toggle);
    logic [8:0] full;
    logic [7:0] exp;
    int lat, en_cnt, ovl, sr_bad;
    bit seen;
    full = {1'b0, a} + {1'b0, b};
    exp  = full[7:0];
    check("idle_s_ready", WB'(sr8), WB'(1));
    check("idle_busy", WB'(busy8), WB'(0));
    ce8 = 1'b1; sv8 = 1'b1; a0_8 = a; a1_8 = b; mr8 = (hold == 0);
    #1 check("add_load", WB'(ld8), WB'(1));
    @(posedge clk);
    #1 sv8 = 1'b0; a0_8 = 8'($urandom); a1_8 = 8'($urandom);
    lat = 0; en_cnt = 0; ovl = 0; sr_bad = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mv8) begin
        seen = 1;
        ce8  = 1'b1;
      end else begin
        if (ld8 && en8) ovl++;
        if (sr8) sr_bad++;
        ce8 = toggle ? ~ce8 : 1'b1;
        if (en8 && ce8) en_cnt++;
      end
    end
    check("valid_seen", WB'(seen), WB'(1));
    if (!toggle) check("latency", WB'(lat), WB'(9));
    check("en_cycles", WB'(en_cnt), WB'(8));
    check("load_en_overlap", WB'(ovl), WB'(0));
    check("s_ready_shift", WB'(sr_bad), WB'(0));
    check("sum", WB'(sum8), WB'(exp));
    check("en_off_done", WB'(en8), WB'(0));
    check("s_ready_done", WB'(sr8), WB'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", WB'(mv8), WB'(1));
      check("hold_sum", WB'(sum8), WB'(exp));
      check("hold_s_ready", WB'(sr8), WB'(0));
    end
    mr8 = 1'b1;
    @(negedge clk);
    check("valid_drop", WB'(mv8), WB'(0));
    mr8 = 1'b0;
  endtask

  initial begin
    logic [WB:0]   big_full;
    logic [WB-1:0] big_exp;
    int lat, en_cnt;
    bit seen;

    rst = 1'b0;
    ce8 = 1'b1; sv8 = 1'b0; a0_8 = '0; a1_8 = '0; mr8 = 1'b0;
    ceb = 1'b1; svb = 1'b0; a0_b = '0; a1_b = '0; mrb = 1'b0;

    #12;
    check("rst_m_valid", WB'(mv8), WB'(0));
    check("rst_sum", WB'(sum8), WB'(0));
    check("rst_busy", WB'(busy8), WB'(0));
    check("rst_add_en", WB'(en8), WB'(0));
    check("rst_add_load", WB'(ld8), WB'(0));
    check("rst_big_sum", sumb, '0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel_s_ready", WB'(sr8), WB'(1));
    @(negedge clk);

    run8(8'h35, 8'h4A, 0, 0);
    run8(8'hFF, 8'h01, 0, 0);
    run8(8'hAA, 8'h55, 0, 0);
    run8(8'h35, 8'h4A, 5, 0);
    run8(8'h35, 8'h4A, 0, 1);

    // Reset in the middle of SHIFT drops the partial sum.
    sv8 = 1'b1; a0_8 = 8'h35; a1_8 = 8'h4A; ce8 = 1'b1;
    @(posedge clk);
    #1 sv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("mid_busy", WB'(busy8), WB'(1));
    rst = 1'b0;
    #1;
    check("mrst_m_valid", WB'(mv8), WB'(0));
    check("mrst_sum", WB'(sum8), WB'(0));
    check("mrst_busy", WB'(busy8), WB'(0));
    check("mrst_add_en", WB'(en8), WB'(0));
    @(negedge clk);
    rst = 1'b1;
    #1 check("mrst_s_ready", WB'(sr8), WB'(1));
    @(negedge clk);
    run8(8'h12, 8'h34, 0, 0);

    for (int k = 0; k < 10; k++)
      run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    // Full-width transaction with 1024-bit operands.
    for (int k = 0; k < 32; k++) begin
      a0_b[k*32 +: 32] = $urandom;
      a1_b[k*32 +: 32] = $urandom;
    end
    a0_b[WB-1] = 1'b0;
    a1_b[WB-1] = 1'b0;
    big_full = {1'b0, a0_b} + {1'b0, a1_b};
    big_exp  = big_full[WB-1:0];
    svb = 1'b1; mrb = 1'b1;
    #1 check("big_add_load", WB'(ldb), WB'(1));
    @(posedge clk);
    #1 svb = 1'b0; a0_b = '0; a1_b = '0;
    lat = 0; en_cnt = 0; seen = 0;
    while (!seen && lat < 1200) begin
      @(negedge clk);
      lat++;
      if (mvb) seen = 1;
      else if (enb) en_cnt++;
    end
    check("big_valid_seen", WB'(seen), WB'(1));
    check("big_latency", WB'(lat), WB'(1026));
    check("big_en_cycles", WB'(en_cnt), WB'(1025));
    check("big_sum", sumb, big_exp);
    check("big_carry_bit", WB'(sumb[WB-1]), WB'(big_exp[WB-1]));
    @(negedge clk);
    check("big_valid_drop", WB'(mvb), WB'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serial_sum_collector.md
Name: bit_serial_sum_collector

Overview:
- Control and collection stage directly downstream of the bit-serial adder.
- Accepts an operand pair over a valid/ready handshake and issues the adder's load strobe with the operands.
- Asserts the adder's enable for exactly DATA_WIDTH cycles, shifting each returned sum bit into a parallel result register.
- Presents the DATA_WIDTH-bit sum over a valid/ready handshake. Used by the modular-arithmetic datapath to turn serial sums back into words.

Parameters:
DATA_WIDTH, 1025, operand/sum width; the 1024-bit operand plus 1 headroom bit, so the sum is taken modulo 2^DATA_WIDTH.
CNT_WIDTH, $clog2(DATA_WIDTH+1), bit-counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset; asserted when 0.
ce  input  1  clock enable; when 0 all state holds. Also wired to the adder's ce.
s_valid  input  1  operand pair valid.
s_ready  output  1  block can accept operands.
s_a0  input  DATA_WIDTH  operand 0.
s_a1  input  DATA_WIDTH  operand 1.
add_load  output  1  load strobe to the adder.
add_en  output  1  shift enable to the adder.
add_a0  output  DATA_WIDTH  operand 0 to the adder; combinational pass-through of s_a0.
add_a1  output  DATA_WIDTH  operand 1 to the adder; combinational pass-through of s_a1.
add_bit  input  1  current sum bit from the adder.
m_valid  output  1  sum valid.
m_ready  input  1  downstream accepts the sum.
m_sum  output  DATA_WIDTH  collected sum, bit 0 = LSB.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, m_sum=0.
  - Outputs: m_valid=0, add_en=0, add_load=0, busy=0, s_ready=1 once rst releases.
- States: IDLE, SHIFT, DONE. The FSM advances and registers update only on edges where ce=1.
- IDLE:
  - s_ready=1.
  - add_load = s_valid & ce, combinational. The adder and this block see the accept on the same edge.
  - On s_valid & ce: counter <= 0, go to SHIFT.
- SHIFT:
  - add_en=1, s_ready=0.
  - Each ce edge: m_sum <= {add_bit, m_sum[DATA_WIDTH-1:1]}, counter++.
  - The edge that captures the bit with counter == DATA_WIDTH-1 goes to DONE.
  - add_en is therefore high for exactly DATA_WIDTH ce-cycles, never more, because the adder is only correct under that limit.
- DONE:
  - m_valid=1, add_en=0, m_sum held stable.
  - On m_ready & ce: go to IDLE.
  - m_valid must not drop before m_ready.
- Latency: accept at edge k; bit i is captured at edge k+1+i; m_valid is high in the cycle after edge k+DATA_WIDTH. With no ce stalls, that is DATA_WIDTH+1 cycles from acceptance to the first m_valid cycle.
- Throughput: one sum per DATA_WIDTH+2 cycles minimum. s_ready is low in SHIFT and DONE, and there is no accept in the same cycle as m_ready.
- ce=0 mid-SHIFT: no capture, no counter change. The adder freezes because it shares ce, so bit alignment is preserved.
- Carry out of the MSB is discarded (modulo 2^DATA_WIDTH).
- Reset asserted mid-SHIFT or in DONE: immediate return to IDLE with all outputs at reset values. A partial sum is lost and never presented.
- add_load and add_en are never high in the same cycle.

Test Plan:
- DATA_WIDTH=8, s_a0=8'h35, s_a1=8'h4A, m_ready=1 -> add_en high exactly 8 cycles; m_sum=8'h7F; m_valid is first seen 9 cycles after the accept edge.
- DATA_WIDTH=8, 8'hFF+8'h01 -> m_sum=8'h00 (carry dropped); then 8'hAA+8'h55 back-to-back -> 8'hFF. s_ready is low throughout SHIFT/DONE.
- DATA_WIDTH=8, m_ready held 0 for 5 cycles after m_valid -> m_valid and m_sum=8'h7F stable all 5 cycles, s_ready=0. Next accept only after the m_ready edge.
- ce toggled 0/1 every other cycle during SHIFT, 8'h35+8'h4A -> m_sum=8'h7F; add_en asserted for 8 ce-high cycles.
- rst pulsed low after 3 SHIFT bits -> m_valid=0, m_sum=0, busy=0 immediately. A following 8'h12+8'h34 yields 8'h46.
- Default DATA_WIDTH=1025, random 1024-bit operands (bit 1024 = 0) -> m_sum equals the reference sum including the carry into bit 1024; latency 1026 cycles.
